// File: rtl/mem_store_buffer.sv
// mem_store_buffer: in-order store FIFO that drains into word-write memory by read-modify-write and forwards pending bytes to loads
module mem_store_buffer #(
    parameter int DEPTH = 4
) (
    input  logic        Clk,
    input  logic        reset,
    input  logic        st_valid,
    input  logic [31:0] st_addr,
    input  logic [31:0] st_data,
    input  logic [3:0]  st_be,
    input  logic [31:0] st_pc,
    output logic        st_ready,
    input  logic        ld_valid,
    input  logic [31:0] ld_addr,
    output logic [31:0] ld_data,
    output logic        empty,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wd,
    output logic        dm_we,
    output logic [31:0] dm_wpc,
    input  logic [31:0] dm_rd
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [29:0]    e_addr [DEPTH];
    logic [31:0]    e_data [DEPTH];
    logic [3:0]     e_be   [DEPTH];
    logic [31:0]    e_pc   [DEPTH];
    logic [AW-1:0]  head, tail, fidx;
    logic [CW-1:0]  count;
    logic           push, drain, unused_ok;

    assign unused_ok = ^{st_addr[1:0], ld_addr[1:0]};
    assign st_ready  = count != FULL;
    assign empty     = count == '0;
    assign push      = st_valid && st_ready;
    assign drain     = !reset && !ld_valid && !empty;
    assign dm_we     = drain;
    assign dm_wpc    = e_pc[head];
    assign dm_addr   = ld_valid ? {ld_addr[31:2], 2'b00} : !empty ? {e_addr[head], 2'b00} : 32'h0;

    always_comb begin
        dm_wd = dm_rd;
        for (int b = 0; b < 4; b++)
            if (e_be[head][b]) dm_wd[8*b +: 8] = e_data[head][8*b +: 8];
    end

    // Walk oldest to youngest so younger matching bytes win.
    always_comb begin
        ld_data = dm_rd;
        fidx = head;
        for (int k = 0; k < DEPTH; k++) begin
            fidx = head + AW'(k);
            for (int b = 0; b < 4; b++)
                if (CW'(k) < count && e_addr[fidx] == ld_addr[31:2] && e_be[fidx][b])
                    ld_data[8*b +: 8] = e_data[fidx][8*b +: 8];
        end
    end

    always_ff @(posedge Clk) begin
        if (reset) begin
            count <= '0;
            head  <= '0;
            tail  <= '0;
        end else begin
            if (push) begin
                e_addr[tail] <= st_addr[31:2];
                e_data[tail] <= st_data;
                e_be[tail]   <= st_be;
                e_pc[tail]   <= st_pc;
                tail         <= tail + 1'b1;
            end
            if (drain) head <= head + 1'b1;
            count <= count + CW'(push) - CW'(drain);
        end
    end
endmodule
